// File: rtl/gpio_cfg_pkg.sv
// rtl/gpio_cfg_pkg.sv - shared states and defaults for the gpio config serializer
package gpio_cfg_pkg;

  localparam int PADS_PER_CHAIN_DEFAULT = 19;
  localparam int CFG_BITS_DEFAULT       = 13;

  // Power-on management-standard output configuration for one pad
  localparam logic [12:0] MGMT_STD_OUTPUT = 13'h1809;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    FETCH,
    SLO,
    SHI,
    LOAD
  } state_t;

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// rtl/gpio_cfg_clkdiv.sv - half-period tick generator with restart
module gpio_cfg_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // tick marks the last cycle of a half period
  assign tick = (cnt == CW'(CLK_DIV - 1));

  // free-running count, realigned whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/gpio_cfg_serializer.sv
// rtl/gpio_cfg_serializer.sv - shifts per-pad config words into both gpio chains, optional GPIO_CFG_BITBANG_EN
module gpio_cfg_serializer
  import gpio_cfg_pkg::*;
#(
  parameter int PADS_PER_CHAIN = PADS_PER_CHAIN_DEFAULT,
  parameter int CFG_BITS       = CFG_BITS_DEFAULT,
  parameter int CLK_DIV        = 2,
  parameter int RST_CYCLES     = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start,
  output logic                xfer_busy,
  output logic                xfer_done,
  output logic [4:0]          cfg_rd_idx,
  output logic                cfg_rd_en,
  input  logic [CFG_BITS-1:0] cfg_rd_data_1,
  input  logic [CFG_BITS-1:0] cfg_rd_data_2,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_resetn,
  output logic                serial_data_1,
  output logic                serial_data_2
`ifdef GPIO_CFG_BITBANG_EN
  ,
  input  logic                bitbang_en,
  input  logic [4:0]          bitbang_bits
`endif
);

  localparam int WW = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t              state, state_nxt;
  logic [WW-1:0]       w, w_nxt;
  logic [BW-1:0]       b, b_nxt;
  logic [RW-1:0]       rcnt, rcnt_nxt;
  logic                ph, ph_nxt;          // FETCH: read/capture, LOAD: low/pulse
  logic [CFG_BITS-1:0] sreg_1, sreg_1_nxt, sreg_2, sreg_2_nxt;
  logic                busy_nxt, done_nxt, rd_en_nxt;
  logic [4:0]          idx_nxt;
  logic                clock_nxt, load_nxt, resetn_nxt, data_1_nxt, data_2_nxt;
  logic                tick, restart;

  // every state change restarts the half-period timer
  assign restart = (state_nxt != state);

  gpio_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .restart (restart),
    .tick    (tick)
  );

  // next state and next value of every registered output
  always_comb begin
    state_nxt  = state;
    w_nxt      = w;
    b_nxt      = b;
    rcnt_nxt   = rcnt;
    ph_nxt     = ph;
    sreg_1_nxt = sreg_1;
    sreg_2_nxt = sreg_2;
    busy_nxt   = xfer_busy;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (xfer_start) begin
        state_nxt = CRST;
        busy_nxt  = 1'b1;
        rcnt_nxt  = '0;
      end
      CRST: if (rcnt == RW'(RST_CYCLES - 1)) begin
        state_nxt = FETCH;
        w_nxt     = WW'(PADS_PER_CHAIN - 1);
        ph_nxt    = 1'b0;
      end else begin
        rcnt_nxt = rcnt + 1'b1;
      end
      FETCH: if (!ph) begin
        ph_nxt = 1'b1;
      end else begin
        sreg_1_nxt = cfg_rd_data_1;
        sreg_2_nxt = cfg_rd_data_2;
        b_nxt      = BW'(CFG_BITS - 1);
        state_nxt  = SLO;
      end
      SLO: if (tick) state_nxt = SHI;
      SHI: if (tick) begin
        if (b != '0) begin
          b_nxt     = b - 1'b1;
          state_nxt = SLO;
        end else if (w != '0) begin
          w_nxt     = w - 1'b1;
          ph_nxt    = 1'b0;
          state_nxt = FETCH;
        end else begin
          ph_nxt    = 1'b0;
          state_nxt = LOAD;
        end
      end
      LOAD: if (tick) begin
        if (!ph) begin
          ph_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // outputs follow the state being entered so they line up with it
    clock_nxt  = (state_nxt == SHI);
    load_nxt   = (state_nxt == LOAD) && ph_nxt;
    resetn_nxt = (state_nxt != CRST);
    rd_en_nxt  = (state_nxt == FETCH) && !ph_nxt;
    idx_nxt    = rd_en_nxt ? 5'(w_nxt) : cfg_rd_idx;
    data_1_nxt = (state_nxt == SLO) ? sreg_1_nxt[b_nxt] : serial_data_1;
    data_2_nxt = (state_nxt == SLO) ? sreg_2_nxt[b_nxt] : serial_data_2;

`ifdef GPIO_CFG_BITBANG_EN
    // software bit-bang owns the pads and aborts any transfer in flight
    if (bitbang_en) begin
      state_nxt  = IDLE;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      rd_en_nxt  = 1'b0;
      data_2_nxt = bitbang_bits[4];
      data_1_nxt = bitbang_bits[3];
      clock_nxt  = bitbang_bits[2];
      load_nxt   = bitbang_bits[1];
      resetn_nxt = bitbang_bits[0];
    end
`endif
  end

  // state, counters and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      w             <= '0;
      b             <= '0;
      rcnt          <= '0;
      ph            <= 1'b0;
      sreg_1        <= '0;
      sreg_2        <= '0;
      xfer_busy     <= 1'b0;
      xfer_done     <= 1'b0;
      cfg_rd_en     <= 1'b0;
      cfg_rd_idx    <= '0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b1;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      state         <= state_nxt;
      w             <= w_nxt;
      b             <= b_nxt;
      rcnt          <= rcnt_nxt;
      ph            <= ph_nxt;
      sreg_1        <= sreg_1_nxt;
      sreg_2        <= sreg_2_nxt;
      xfer_busy     <= busy_nxt;
      xfer_done     <= done_nxt;
      cfg_rd_en     <= rd_en_nxt;
      cfg_rd_idx    <= idx_nxt;
      serial_clock  <= clock_nxt;
      serial_load   <= load_nxt;
      serial_resetn <= resetn_nxt;
      serial_data_1 <= data_1_nxt;
      serial_data_2 <= data_2_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// tb/tb_gpio_cfg_serializer.sv - randomized self-checking bench with chain and waveform model
module tb_gpio_cfg_serializer;
  import gpio_cfg_pkg::*;

  localparam int PADS  = 19;
  localparam int BITS  = 13;
  localparam int DIV   = 2;
  localparam int RSTC  = 4;
  localparam int CHAIN = PADS * BITS;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic xfer_start = 1'b0;
  logic xfer_busy, xfer_done, cfg_rd_en;
  logic [4:0] cfg_rd_idx;
  logic [BITS-1:0] cfg_rd_data_1 = '0;
  logic [BITS-1:0] cfg_rd_data_2 = '0;
  logic serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2;
`ifdef GPIO_CFG_BITBANG_EN
  logic bitbang_en = 1'b0;
  logic [4:0] bitbang_bits = '0;
`endif

  gpio_cfg_serializer #(.PADS_PER_CHAIN(PADS), .CFG_BITS(BITS), .CLK_DIV(DIV), .RST_CYCLES(RSTC)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .xfer_start(xfer_start),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done),
    .cfg_rd_idx(cfg_rd_idx), .cfg_rd_en(cfg_rd_en),
    .cfg_rd_data_1(cfg_rd_data_1), .cfg_rd_data_2(cfg_rd_data_2),
    .serial_clock(serial_clock), .serial_load(serial_load), .serial_resetn(serial_resetn),
    .serial_data_1(serial_data_1), .serial_data_2(serial_data_2)
`ifdef GPIO_CFG_BITBANG_EN
    , .bitbang_en(bitbang_en), .bitbang_bits(bitbang_bits)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // housekeeping register file: mem_1[i] = pad i, mem_2[i] = pad 37-i
  logic [BITS-1:0] mem_1 [PADS];
  logic [BITS-1:0] mem_2 [PADS];
  always @(posedge wb_clk_i) begin
    if (cfg_rd_en) begin
      cfg_rd_data_1 <= mem_1[cfg_rd_idx];
      cfg_rd_data_2 <= mem_2[cfg_rd_idx];
    end
  end

  typedef struct {
    logic clk, load, rstn, busy, done, rd_en;
    logic [4:0] idx;
    logic chk_data, d1, d2;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int rise_cnt = 0, load_cnt = 0, done_cnt = 0, low_cycles = 0;
  int idx_log[$];
  logic [CHAIN-1:0] ch_1 = '0, ch_2 = '0, snap_1 = '0, snap_2 = '0;
  logic armed = 1'b0, prev_clk = 1'b0, prev_load = 1'b0, bb_prev = 1'b0;
  logic [4:0] bits_prev = '0;

  function automatic exp_t mk(logic c, logic l, logic r, logic bz, logic dn, logic re,
                              logic [4:0] ix, logic cd, logic d1, logic d2);
    exp_t e;
    e.clk = c; e.load = l; e.rstn = r; e.busy = bz; e.done = dn; e.rd_en = re;
    e.idx = ix; e.chk_data = cd; e.d1 = d1; e.d2 = d2;
    return e;
  endfunction

  // expected per-cycle waveform of one transfer, starting the cycle busy rises
  task automatic build_trace();
    for (int i = 0; i < RSTC; i++) q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int w = PADS - 1; w >= 0; w--) begin
      q.push_back(mk(0, 0, 1, 1, 0, 1, 5'(w), 0, 0, 0));
      q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = BITS - 1; k >= 0; k--) begin
        for (int h = 0; h < 2 * DIV; h++)
          q.push_back(mk(h >= DIV, 0, 1, 1, 0, 0, 0, 1, mem_1[w][k], mem_2[w][k]));
      end
    end
    for (int h = 0; h < 2 * DIV; h++) q.push_back(mk(0, h >= DIV, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
  endtask

  task automatic monitor();
    exp_t e;
    logic ok;
    forever begin
      @(negedge wb_clk_i);
      if (armed) begin
        if (bb_prev)
          e = mk(bits_prev[2], bits_prev[1], bits_prev[0], 0, 0, 0, 0, 1, bits_prev[3], bits_prev[4]);
        else if (q.size() > 0)
          e = q.pop_front();
        else
          e = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        ok = (serial_clock === e.clk) && (serial_load === e.load) && (serial_resetn === e.rstn) &&
             (xfer_busy === e.busy) && (xfer_done === e.done) && (cfg_rd_en === e.rd_en) &&
             (!e.rd_en || cfg_rd_idx === e.idx) &&
             (!e.chk_data || (serial_data_1 === e.d1 && serial_data_2 === e.d2));
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL trace t=%0t got clk=%b load=%b rstn=%b busy=%b done=%b en=%b idx=%0d d1=%b d2=%b want clk=%b load=%b rstn=%b busy=%b done=%b en=%b idx=%0d d1=%b d2=%b",
                   $time, serial_clock, serial_load, serial_resetn, xfer_busy, xfer_done, cfg_rd_en,
                   cfg_rd_idx, serial_data_1, serial_data_2, e.clk, e.load, e.rstn, e.busy, e.done,
                   e.rd_en, e.idx, e.d1, e.d2);
        end
        // physical chain model: shift on every rising serial_clock, latch on load
        if (serial_clock && !prev_clk) begin
          ch_1 = {ch_1[CHAIN-2:0], serial_data_1};
          ch_2 = {ch_2[CHAIN-2:0], serial_data_2};
          rise_cnt++;
        end
        if (serial_load && !prev_load) begin
          snap_1 = ch_1;
          snap_2 = ch_2;
          load_cnt++;
        end
        if (xfer_done) done_cnt++;
        if (!serial_resetn) low_cycles++;
        if (cfg_rd_en) idx_log.push_back(int'(cfg_rd_idx));
      end
      prev_clk  = serial_clock;
      prev_load = serial_load;
      bb_prev   = 1'b0;
      if (wb_rst_i) begin
        q.delete();
        armed = 1'b1;
      end
`ifdef GPIO_CFG_BITBANG_EN
      else if (bitbang_en) begin
        q.delete();
        bb_prev   = 1'b1;
        bits_prev = bitbang_bits;
      end
`endif
      else if (xfer_start && q.size() == 0) begin
        build_trace();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int chain_errs();
    int n = 0;
    for (int p = 0; p < PADS; p++) begin
      if (snap_1[p*BITS +: BITS] !== mem_1[p]) n++;
      if (snap_2[p*BITS +: BITS] !== mem_2[p]) n++;
    end
    return n;
  endfunction

  function automatic logic [BITS-1:0] pad_1(int p);
    return snap_1[p*BITS +: BITS];
  endfunction

  function automatic logic [BITS-1:0] pad_2(int p);
    return snap_2[(37 - p)*BITS +: BITS];
  endfunction

  task automatic pulse_start();
    @(posedge wb_clk_i); #1 xfer_start = 1'b1;
    @(posedge wb_clk_i); #1 xfer_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target);
    int n = 0;
    while (done_cnt < target && n < 4000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    chk(name, 32'(done_cnt >= target), 1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < PADS; i++) begin
      mem_1[i] = BITS'($urandom);
      mem_2[i] = BITS'($urandom);
    end
  endtask

  task automatic stimulus();
    int r0, d0, l0, n, errs;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    chk("reset_outputs", {serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2,
                          xfer_busy, xfer_done, cfg_rd_en, cfg_rd_idx}, 13'b0010000000000);

    // all pads at the management standard output word
    for (int i = 0; i < PADS; i++) begin
      mem_1[i] = MGMT_STD_OUTPUT;
      mem_2[i] = MGMT_STD_OUTPUT;
    end
    r0 = rise_cnt; d0 = done_cnt; l0 = load_cnt; low_cycles = 0;
    pulse_start();
    wait_done("t1_done_seen", d0 + 1);
    repeat (5) @(posedge wb_clk_i);
    #1;
    chk("t1_rises", rise_cnt - r0, 247);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_load_count", load_cnt - l0, 1);
    chk("t1_resetn_low", low_cycles, 4);
    chk("t1_pad0", pad_1(0), 13'h1809);
    chk("t1_pad37", pad_2(37), 13'h1809);
    chk("t1_chain", chain_errs(), 0);

    // pad-indexed words
    for (int i = 0; i < PADS; i++) begin
      mem_1[i] = BITS'(i);
      mem_2[i] = BITS'(13'h1000 | i);
    end
    idx_log.delete();
    d0 = done_cnt;
    pulse_start();
    wait_done("t2_done_seen", d0 + 1);
    #1;
    chk("t2_pad5", pad_1(5), 13'h0005);
    chk("t2_pad32", pad_2(32), 13'h1005);
    chk("t2_chain", chain_errs(), 0);
    chk("t2_idx_count", idx_log.size(), 19);
    errs = 0;
    for (int j = 0; j < idx_log.size(); j++) if (idx_log[j] != 18 - j) errs++;
    chk("t2_idx_order", errs, 0);

    // a second start while busy is dropped
    randomize_mem();
    d0 = done_cnt; l0 = load_cnt;
    pulse_start();
    repeat (49) @(posedge wb_clk_i);
    pulse_start();
    wait_done("t3_done_seen", d0 + 1);
    repeat (1200) @(posedge wb_clk_i);
    #1;
    chk("t3_done_count", done_cnt - d0, 1);
    chk("t3_load_count", load_cnt - l0, 1);
    chk("t3_chain", chain_errs(), 0);

    // reset at the 100th rising serial clock edge
    randomize_mem();
    r0 = rise_cnt; d0 = done_cnt; l0 = load_cnt; n = 0;
    pulse_start();
    while (rise_cnt - r0 < 100 && n < 3000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    chk("t4_reached_100", rise_cnt - r0, 100);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
    chk("t4_reset_outputs", {serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2,
                             xfer_busy, xfer_done, cfg_rd_en, cfg_rd_idx}, 13'b0010000000000);
    repeat (1200) @(posedge wb_clk_i);
    #1;
    chk("t4_no_load", load_cnt - l0, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    randomize_mem();
    pulse_start();
    wait_done("t4_fresh_done", d0 + 1);
    #1;
    chk("t4_fresh_chain", chain_errs(), 0);

`ifdef GPIO_CFG_BITBANG_EN
    @(posedge wb_clk_i); #1 bitbang_en = 1'b1; bitbang_bits = 5'b11011;
    @(posedge wb_clk_i); #1;
    chk("bb_outputs", {serial_data_2, serial_data_1, serial_clock, serial_load, serial_resetn}, 5'b11011);
    xfer_start = 1'b1;
    @(posedge wb_clk_i); #1 xfer_start = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("bb_no_busy", xfer_busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1 bitbang_bits = 5'($urandom);
    end
    @(posedge wb_clk_i); #1 bitbang_en = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    d0 = done_cnt; l0 = load_cnt;
    pulse_start();
    repeat (300) @(posedge wb_clk_i);
    #1 bitbang_en = 1'b1; bitbang_bits = 5'b00001;
    repeat (3) @(posedge wb_clk_i);
    #1 bitbang_en = 1'b0;
    repeat (1200) @(posedge wb_clk_i);
    #1;
    chk("bb_abort_no_done", done_cnt - d0, 0);
    chk("bb_abort_no_load", load_cnt - l0, 0);
    chk("bb_abort_idle", xfer_busy, 0);
    randomize_mem();
    pulse_start();
    wait_done("bb_after_done", d0 + 1);
    #1;
    chk("bb_after_chain", chain_errs(), 0);
`endif
    repeat (5) @(posedge wb_clk_i);
  endtask

  initial begin
    fork
      monitor();
      begin
        stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join
  end

endmodule

// File: doc/gpio_cfg_serializer.md
Name: gpio_cfg_serializer

Overview:
- Drives the GPIO pad configuration shift chains.
- Reads per-pad 13-bit config words from the housekeeping register file and shifts them serially into two daisy-chained gpio control chains (user 1: pads 0-18; user 2: pads 37-19).
- Then pulses load to apply the whole chain.
- Sits between the housekeeping register block (upstream) and the per-pad gpio control blocks (downstream); this is the hardware path that the SPI bit-bang register otherwise drives by hand.

Parameters:
- PADS_PER_CHAIN, 19, pads on each chain
- CFG_BITS, 13, config bits per pad
- CLK_DIV, 2, wb_clk_i cycles per serial_clock half-period (min 1)
- RST_CYCLES, 4, wb_clk_i cycles serial_resetn is held low before shifting

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- xfer_start  in  1  single-cycle request to start a transfer
- xfer_busy  out  1  high from accepted start until done
- xfer_done  out  1  one-cycle pulse after load completes
- cfg_rd_idx  out  5  pad-pair index requested (0..PADS_PER_CHAIN-1)
- cfg_rd_en  out  1  read strobe for cfg_rd_idx
- cfg_rd_data_1  in  CFG_BITS  chain-1 word for pad cfg_rd_idx; valid 1 cycle after cfg_rd_en
- cfg_rd_data_2  in  CFG_BITS  chain-2 word for pad 37-cfg_rd_idx; valid 1 cycle after cfg_rd_en
- serial_clock  out  1  chain shift clock
- serial_load  out  1  chain load strobe
- serial_resetn  out  1  chain reset, active low
- serial_data_1  out  1  chain-1 data
- serial_data_2  out  1  chain-2 data

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset (wb_rst_i) is synchronous and active-high. All outputs are registered.
- Reset values:
  - serial_clock=0, serial_load=0, serial_resetn=1
  - serial_data_1=0, serial_data_2=0
  - xfer_busy=0, xfer_done=0, cfg_rd_en=0, cfg_rd_idx=0
  - state=IDLE
- IDLE:
  - xfer_start=1 -> xfer_busy=1 next cycle, go to CRST.
  - xfer_start while busy is ignored; no queueing.
- CRST: serial_resetn=0 for RST_CYCLES cycles, then 1; word counter w = PADS_PER_CHAIN-1; go to FETCH.
  - Shift order is the furthest pad first, so pad 0 / pad 37 are shifted last.
- FETCH: cfg_rd_en=1 and cfg_rd_idx=w for 1 cycle. Next cycle, capture both data inputs into 13-bit shift registers; bit counter b = CFG_BITS-1; go to SLO.
- SLO:
  - serial_clock=0; serial_data_1/2 = shift_reg[b], MSB first.
  - Hold CLK_DIV cycles, then SHI.
- SHI: serial_clock=1 for CLK_DIV cycles. Data is stable across the whole rising edge. Then:
  - b>0: b-1, back to SLO.
  - b==0 and w>0: w-1, serial_clock returns 0, go to FETCH.
  - b==0 and w==0: go to LOAD.
- LOAD:
  - serial_clock=0 for CLK_DIV cycles.
  - Then serial_load=1 for CLK_DIV cycles, then 0.
  - Then xfer_done=1 for 1 cycle, xfer_busy=0, back to IDLE.
- Totals: exactly PADS_PER_CHAIN*CFG_BITS rising edges (247 at defaults) per transfer, and exactly one load pulse.
- serial_clock stays 0 during FETCH, so data changes only while the clock is low.
- wb_rst_i mid-transfer: immediate return to reset values. serial_load is never asserted; the partial shift has no effect until the next full transfer.
- Counters are sized $clog2 of their maxima; no wrap-around is reachable.

Optional Feature:
- Macro: GPIO_CFG_BITBANG_EN.
- When defined:
  - Adds inputs bitbang_en (1) and bitbang_bits (5): {data_2, data_1, clock, load, resetn}.
  - While bitbang_en=1, the serial_* outputs are registered copies of bitbang_bits, and xfer_start is ignored in IDLE.
  - Asserting bitbang_en during a transfer aborts it to IDLE without xfer_done.
- When undefined: no such ports; the FSM alone drives the outputs.

Decomposition:
- Package gpio_cfg_pkg:
  - state enum (IDLE, CRST, FETCH, SLO, SHI, LOAD)
  - CFG_BITS and PADS_PER_CHAIN defaults
  - MGMT_STD_OUTPUT constant 13'h1809
- One sub-module, gpio_cfg_clkdiv: half-period tick generator with restart input, used by SLO/SHI/LOAD.

Test Plan:
- All words 13'h1809, CLK_DIV=2: bench model of 19x13-bit chains captures 0x1809 in every pad at load; exactly 247 serial_clock rises; xfer_done 1 cycle.
- Pad i word = i, pad 37-i word = 0x1000|i: after load, chain-1 pad 5 = 0x0005 and chain-2 pad 32 = 0x1005; cfg_rd_idx sequence 18..0.
- xfer_start pulsed at cycle 50 of a transfer: ignored; single transfer, single done.
- wb_rst_i at 100th rising edge: all outputs at reset values next cycle; no load pulse; a fresh xfer_start completes normally.
- serial_resetn held low exactly RST_CYCLES=4 cycles before the first serial_clock rise; data never changes while serial_clock=1.
- GPIO_CFG_BITBANG_EN: bitbang_en=1, bits=5'b11011 -> data_2=1, data_1=1, clock=0, load=1, resetn=1 one cycle later; xfer_start produces no busy.
